// File: rtl/lsu_load_queue_if.sv
// Signal bundle between the core, the MMU, the data bus and the load queue.
// slave is the queue's view; master is the environment's view.
interface lsu_load_queue_if #(
   parameter int TAG_W = 6
);
   logic             flush;
   logic             issue_valid;
   logic             issue_ready;
   logic [2:0]       issue_op;
   logic [31:0]      issue_vaddr;
   logic [TAG_W-1:0] issue_tag;
   logic [31:0]      mmu_vaddr;
   logic [31:0]      mmu_paddr;
   logic             mmu_uncached;
   logic             mmu_miss;
   logic             mmu_invalid;
   logic             mmu_illegal;
   logic             dbus_request;
   logic             dbus_ready;
   logic [31:0]      dbus_paddr;
   logic [3:0]       dbus_byteenable;
   logic             dbus_uncached;
   logic             dbus_rvalid;
   logic [31:0]      dbus_rddata;
   logic             res_valid;
   logic             res_ready;
   logic [TAG_W-1:0] res_tag;
   logic [31:0]      res_data;
   logic             res_ex;
   logic [4:0]       res_exc_code;
   logic [31:0]      res_badvaddr;

   modport slave (
      input  flush, issue_valid, issue_op, issue_vaddr, issue_tag,
      input  mmu_paddr, mmu_uncached, mmu_miss, mmu_invalid, mmu_illegal,
      input  dbus_ready, dbus_rvalid, dbus_rddata, res_ready,
      output issue_ready, mmu_vaddr, dbus_request, dbus_paddr, dbus_byteenable,
      output dbus_uncached, res_valid, res_tag, res_data, res_ex, res_exc_code,
      output res_badvaddr
   );

   modport master (
      output flush, issue_valid, issue_op, issue_vaddr, issue_tag,
      output mmu_paddr, mmu_uncached, mmu_miss, mmu_invalid, mmu_illegal,
      output dbus_ready, dbus_rvalid, dbus_rddata, res_ready,
      input  issue_ready, mmu_vaddr, dbus_request, dbus_paddr, dbus_byteenable,
      input  dbus_uncached, res_valid, res_tag, res_data, res_ex, res_exc_code,
      input  res_badvaddr
   );
endinterface

// File: rtl/lsu_load_queue.sv
// In-order load queue: checks alignment/translation at issue, sends reads in order,
// extends returned data and retires results strictly from the head.
module lsu_load_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   lsu_load_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = AW + 4;

   typedef enum logic [1:0] {S_FREE, S_WAIT_BUS, S_IN_FLIGHT, S_DONE} state_t;

   state_t           r_state     [DEPTH];
   state_t           w_state_nxt [DEPTH];
   logic [PW-1:0]    r_head, r_tail, r_send, r_ifh, r_ift;
   logic [CW-1:0]    r_drop;
   logic [AW-1:0]    r_if_idx [DEPTH];
   logic [TAG_W-1:0] r_tag    [DEPTH];
   logic [2:0]       r_op     [DEPTH];
   logic [31:0]      r_vaddr  [DEPTH];
   logic [31:0]      r_paddr  [DEPTH];
   logic [31:0]      r_data   [DEPTH];
   logic             r_unc    [DEPTH];
   logic             r_ex     [DEPTH];
   logic [3:0]       r_be     [DEPTH];
   logic [4:0]       r_code   [DEPTH];

   logic [AW-1:0] w_head_idx, w_tail_idx, w_send_idx, w_ifh_idx, w_ift_idx, w_rsp_idx;
   logic [PW-1:0] w_if_cnt;
   logic          w_full, w_accept, w_send_wait, w_send_skip, w_hs;
   logic          w_if_nempty, w_dropping, w_rv_used, w_rsp;
   logic          w_res_valid, w_retire, w_res_ex;
   logic          w_is_half, w_is_word, w_misal, w_adel, w_tlbl, w_ex;

   function automatic logic [3:0] f_byteenable(input logic [2:0] op, input logic [1:0] a);
      case (op)
         3'd0, 3'd1: f_byteenable = 4'b0001 << a;
         3'd2, 3'd3: f_byteenable = a[1] ? 4'b1100 : 4'b0011;
         default:    f_byteenable = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] f_load_ext(input logic [2:0] op, input logic [31:0] word,
                                              input logic [1:0] off);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (op)
         3'd0:    f_load_ext = {{24{sh[7]}}, sh[7:0]};
         3'd1:    f_load_ext = {24'h0, sh[7:0]};
         3'd2:    f_load_ext = {{16{sh[15]}}, sh[15:0]};
         3'd3:    f_load_ext = {16'h0, sh[15:0]};
         default: f_load_ext = sh;
      endcase
   endfunction

   assign w_head_idx  = r_head[AW-1:0];
   assign w_tail_idx  = r_tail[AW-1:0];
   assign w_send_idx  = r_send[AW-1:0];
   assign w_ifh_idx   = r_ifh[AW-1:0];
   assign w_ift_idx   = r_ift[AW-1:0];
   assign w_rsp_idx   = r_if_idx[w_ifh_idx];

   assign w_full      = (r_head[AW] != r_tail[AW]) && (w_head_idx == w_tail_idx);
   assign w_accept    = bus.issue_valid & ~w_full;
   // Excepting entries sit DONE at the send pointer and are stepped over.
   assign w_send_wait = (r_send != r_tail) && (r_state[w_send_idx] == S_WAIT_BUS);
   assign w_send_skip = (r_send != r_tail) && (r_state[w_send_idx] == S_DONE);
   assign w_hs        = w_send_wait & bus.dbus_ready;

   assign w_if_cnt    = r_ift - r_ifh;
   assign w_if_nempty = (r_ift != r_ifh);
   assign w_dropping  = (r_drop != '0);
   assign w_rv_used   = bus.dbus_rvalid & (w_dropping | w_if_nempty);
   assign w_rsp       = bus.dbus_rvalid & ~w_dropping & w_if_nempty;

   assign w_res_valid = (r_state[w_head_idx] == S_DONE);
   assign w_retire    = w_res_valid & bus.res_ready;
   assign w_res_ex    = w_res_valid & r_ex[w_head_idx];

   assign w_is_half   = (bus.issue_op == 3'd2) || (bus.issue_op == 3'd3);
   assign w_is_word   = bus.issue_op[2];
   assign w_misal     = (w_is_half & bus.issue_vaddr[0]) | (w_is_word & (|bus.issue_vaddr[1:0]));
   assign w_adel      = w_misal | bus.mmu_illegal;
   assign w_tlbl      = bus.mmu_miss | bus.mmu_invalid;
   assign w_ex        = w_adel | w_tlbl;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) w_state_nxt[i] = r_state[i];
      if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++) w_state_nxt[i] = S_FREE;
      end else begin
         if (w_accept) w_state_nxt[w_tail_idx] = w_ex ? S_DONE : S_WAIT_BUS;
         if (w_hs)     w_state_nxt[w_send_idx] = S_IN_FLIGHT;
         if (w_rsp)    w_state_nxt[w_rsp_idx]  = S_DONE;
         if (w_retire) w_state_nxt[w_head_idx] = S_FREE;
      end
   end

   // Outstanding bus reads at flush time become drops, plus any already being dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_state[i] <= S_FREE;
         r_head <= '0;
         r_tail <= '0;
         r_send <= '0;
         r_ifh  <= '0;
         r_ift  <= '0;
         r_drop <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) r_state[i] <= w_state_nxt[i];
         if (bus.flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_send <= '0;
            r_ifh  <= '0;
            r_ift  <= '0;
            r_drop <= r_drop + CW'(w_if_cnt) + CW'(w_hs) - CW'(w_rv_used);
         end else begin
            r_tail <= r_tail + PW'(w_accept);
            r_send <= r_send + PW'(w_hs | w_send_skip);
            r_head <= r_head + PW'(w_retire);
            r_ift  <= r_ift + PW'(w_hs);
            r_ifh  <= r_ifh + PW'(w_rsp);
            if (w_dropping && bus.dbus_rvalid) r_drop <= r_drop - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tag[w_tail_idx]   <= bus.issue_tag;
         r_op[w_tail_idx]    <= bus.issue_op;
         r_vaddr[w_tail_idx] <= bus.issue_vaddr;
         r_paddr[w_tail_idx] <= bus.mmu_paddr;
         r_unc[w_tail_idx]   <= bus.mmu_uncached;
         r_be[w_tail_idx]    <= f_byteenable(bus.issue_op, bus.issue_vaddr[1:0]);
         r_ex[w_tail_idx]    <= w_ex;
         r_code[w_tail_idx]  <= w_adel ? 5'd4 : 5'd2;
         r_data[w_tail_idx]  <= '0;
      end
      if (w_hs)  r_if_idx[w_ift_idx] <= w_send_idx;
      if (w_rsp) r_data[w_rsp_idx] <= f_load_ext(r_op[w_rsp_idx], bus.dbus_rddata,
                                                 r_paddr[w_rsp_idx][1:0]);
   end

   assign bus.issue_ready     = ~w_full;
   assign bus.mmu_vaddr       = bus.issue_vaddr;
   assign bus.dbus_request    = w_send_wait;
   assign bus.dbus_paddr      = w_send_wait ? {r_paddr[w_send_idx][31:2], 2'b00} : '0;
   assign bus.dbus_byteenable = w_send_wait ? r_be[w_send_idx] : '0;
   assign bus.dbus_uncached   = w_send_wait & r_unc[w_send_idx];
   assign bus.res_valid       = w_res_valid;
   assign bus.res_tag         = w_res_valid ? r_tag[w_head_idx] : '0;
   assign bus.res_data        = w_res_valid ? r_data[w_head_idx] : '0;
   assign bus.res_ex          = w_res_ex;
   assign bus.res_exc_code    = w_res_ex ? r_code[w_head_idx] : '0;
   assign bus.res_badvaddr    = w_res_ex ? r_vaddr[w_head_idx] : '0;
endmodule
